sad_row_accumulator: RTL

SAD_ROW_ACCUMULATOR -- requirements
Module: sad_row_accumulator

---
 rtl/sad_row_accumulator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sad_row_accumulator.sv
// sad_row_accumulator
// Folds compressor-tree row results (sum + carry vectors) into one SAD per
// block of ROWS rows. Stage 1 resolves sum + 2*carry, stage 2 accumulates
// with saturation at 2^OUT_W-1. The finished SAD is held until the consumer
// takes it.
// Optional feature: define SAD_MIN_TRACK_EN to track the minimum block SAD
// and the index of the block that produced it (ports min_sad/min_idx/min_clr).
module sad_row_accumulator #(
    parameter int W     = 12,
    parameter int ROWS  = 16,
    parameter int OUT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    output logic             sad_valid,
    input  logic             sad_ready,
    output logic [OUT_W-1:0] sad_out,
    output logic             sad_ovf
`ifdef SAD_MIN_TRACK_EN
    ,
    output logic [OUT_W-1:0] min_sad,
    output logic [7:0]       min_idx,
    input  logic             min_clr
`endif
);

    localparam int CW = $clog2(ROWS);
    localparam int RW = W + 2;
    // One guard bit above the wider of accumulator and row value.
    localparam int SW = ((OUT_W > RW) ? OUT_W : RW) + 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
    localparam logic [SW-1:0] SAT_MAX  = SW'({OUT_W{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FLUSH,
        HOLD
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   row_cnt;
    logic            accept, last_row, done;

    logic            s1_valid, s1_first, s1_last;
    logic [RW-1:0]   s1_val;
    logic            s2_last;

    logic [OUT_W-1:0] acc;
    logic             ovf;
    logic [SW-1:0]    acc_base, sum_ext;
    logic             sum_sat;

    assign accept   = in_valid && in_ready;
    assign last_row = (row_cnt == LAST_ROW);
    assign done     = (state == HOLD) && sad_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_n
        // unassigned, which would infer a latch.
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = last_row ? FLUSH : ACC;
            ACC:   if (accept && last_row) state_n = FLUSH;
            FLUSH: if (s2_last) state_n = HOLD;
            HOLD:  if (sad_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE) || (state == ACC);
        sad_valid = (state == HOLD);
    end

    // Row counter: advances per accepted row, parks on the last row until the
    // result is taken, so it wraps only on block completion.
    always_ff @(posedge clk) begin
        if (rst)                       row_cnt <= '0;
        else if (done)                 row_cnt <= '0;
        else if (accept && !last_row)  row_cnt <= row_cnt + 1'b1;
    end

    // Stage 1: resolve the carry-save pair; carry sits one bit below its weight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_val   <= '0;
        end else begin
            s1_valid <= accept;
            s1_first <= accept && (state == IDLE);
            s1_last  <= accept && last_row;
            if (accept) s1_val <= RW'(in_sum) + (RW'(in_carry) << 1);
        end
    end

    // Stage 2 adder: the first row of a block restarts from zero.
    always_comb begin
        acc_base = s1_first ? '0 : SW'(acc);
        sum_ext  = acc_base + SW'(s1_val);
        sum_sat  = (sum_ext > SAT_MAX);
    end

    // Stage 2 register: saturating accumulate, sticky overflow, cleared when
    // the held result is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            ovf     <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s2_last <= s1_valid && s1_last;
            if (done) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (s1_valid) begin
                acc <= sum_sat ? {OUT_W{1'b1}} : sum_ext[OUT_W-1:0];
                ovf <= sum_sat || (ovf && !s1_first);
            end
        end
    end

    assign sad_out = acc;
    assign sad_ovf = ovf;

`ifdef SAD_MIN_TRACK_EN
    logic [7:0] blk_idx;

    // Block index: counts completed blocks, wraps naturally at 255.
    always_ff @(posedge clk) begin
        if (rst)       blk_idx <= '0;
        else if (done) blk_idx <= blk_idx + 1'b1;
    end

    // Minimum tracker: strict less-than keeps the earliest index on ties.
    always_ff @(posedge clk) begin
        if (rst || min_clr) begin
            min_sad <= '1;
            min_idx <= '0;
        end else if (done && (sad_out < min_sad)) begin
            min_sad <= sad_out;
            min_idx <= blk_idx;
        end
    end
`endif

endmodule
